// File: rtl/cordiv_is_mc.sv
// cordiv_is_mc: multi-channel stochastic divider with in-stream regeneration.
// Each channel regenerates its dividend/divisor streams through saturating
// up/down estimators (unipolar or bipolar), then divides them with a CORDIV
// shuffle buffer. All channels share randNum and the mode input.

// One channel: two estimators, regeneration compare, shuffle buffer, output.
module cordiv_is_mc_lane #(
    parameter int BW     = 8,
    parameter int DEP    = 4,
    parameter int DEPLOG = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          bipolar,
    input  logic          clr,
    input  logic [BW-1:0] randNum,
    input  logic          dividend,
    input  logic          divisor,
    output logic          quotient
);
    localparam logic [BW-1:0] UMAX = {BW{1'b1}};
    localparam logic [BW-1:0] UMIN = {BW{1'b0}};
    localparam logic [BW-1:0] BMAX = {1'b0, {(BW-1){1'b1}}};
    // Bipolar floor is -(2^(BW-1)-1), keeping |cnt| representable in BW-1 bits.
    localparam logic [BW-1:0] BMIN = {1'b1, {(BW-2){1'b0}}, 1'b1};

    logic [BW-1:0]  r_cd;
    logic [BW-1:0]  r_cv;
    logic [DEP-1:0] r_buf;

    logic [BW-1:0]  w_cd_nxt, w_cv_nxt;
    logic [BW-1:0]  w_md, w_mv;
    logic           w_sd, w_sv, w_rd, w_rv, w_quni, w_q;

    // Saturating step; the limits depend on the current mode.
    function automatic logic [BW-1:0] f_step(input logic [BW-1:0] c,
                                             input logic up,
                                             input logic bip);
        logic [BW-1:0] hi, lo;
        hi = bip ? BMAX : UMAX;
        lo = bip ? BMIN : UMIN;
        if (up) f_step = (c == hi) ? c : c + 1'b1;
        else    f_step = (c == lo) ? c : c - 1'b1;
    endfunction

    // Magnitude used for regeneration: raw count, or |cnt|<<1 in bipolar.
    function automatic logic [BW-1:0] f_mag(input logic [BW-1:0] c,
                                            input logic bip);
        logic [BW-1:0] a;
        a = c[BW-1] ? (~c + 1'b1) : c;
        f_mag = bip ? {a[BW-2:0], 1'b0} : c;
    endfunction

    // Regeneration and CORDIV selection from pre-update state.
    always_comb begin
        w_cd_nxt = f_step(r_cd, dividend, bipolar);
        w_cv_nxt = f_step(r_cv, divisor, bipolar);
        w_md     = f_mag(r_cd, bipolar);
        w_mv     = f_mag(r_cv, bipolar);
        w_sd     = bipolar & r_cd[BW-1];
        w_sv     = bipolar & r_cv[BW-1];
        w_rd     = (w_md > randNum);
        w_rv     = (w_mv > randNum);
        w_quni   = w_rv ? w_rd : r_buf[randNum[DEPLOG-1:0]];
        w_q      = w_quni ^ w_sd ^ w_sv;
    end

    // State update: reset or mode-change clear, otherwise advance on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd     <= '0;
            r_cv     <= '0;
            r_buf    <= '0;
            quotient <= 1'b0;
        end else if (en) begin
            if (clr) begin
                r_cd     <= '0;
                r_cv     <= '0;
                r_buf    <= '0;
                quotient <= 1'b0;
            end else begin
                r_cd     <= w_cd_nxt;
                r_cv     <= w_cv_nxt;
                if (w_rv) r_buf <= {r_buf[DEP-2:0], w_rd};
                quotient <= w_q;
            end
        end
    end
endmodule

// Top: mode-change detection and the channel array.
module cordiv_is_mc #(
    parameter int BW     = 8,
    parameter int DEP    = 4,
    parameter int DEPLOG = 2,
    parameter int CH     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          bipolar,
    input  logic [BW-1:0] randNum,
    input  logic [CH-1:0] dividend,
    input  logic [CH-1:0] divisor,
    output logic [CH-1:0] quotient
);
    logic r_mode;
    logic w_clr;

    assign w_clr = (bipolar != r_mode);

    // Mode copy advances only on enabled edges so a toggle made while
    // stalled still produces the clear once en rises.
    always_ff @(posedge clk) begin
        if (rst)     r_mode <= 1'b0;
        else if (en) r_mode <= bipolar;
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        cordiv_is_mc_lane #(.BW(BW), .DEP(DEP), .DEPLOG(DEPLOG)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .bipolar  (bipolar),
            .clr      (w_clr),
            .randNum  (randNum),
            .dividend (dividend[g]),
            .divisor  (divisor[g]),
            .quotient (quotient[g])
        );
    end
endmodule

// File: tb/tb_cordiv_is_mc.sv
// Bench for cordiv_is_mc: integer-level reference model, per-cycle compare,
// directed phases from the test plan plus a randomized soak.
module tb_cordiv_is_mc;
    localparam int BW = 8, DEP = 4, DEPLOG = 2, CH = 2;

    logic          clk = 1'b0;
    logic          rst, en, bipolar;
    logic [BW-1:0] randNum;
    logic [CH-1:0] dividend, divisor;
    logic [CH-1:0] quotient;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int cd [CH];
    int cv [CH];
    bit mbuf [CH][DEP];
    bit [CH-1:0] mq;
    bit mmode;

    cordiv_is_mc #(.BW(BW), .DEP(DEP), .DEPLOG(DEPLOG), .CH(CH)) dut (
        .clk(clk), .rst(rst), .en(en), .bipolar(bipolar), .randNum(randNum),
        .dividend(dividend), .divisor(divisor), .quotient(quotient)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            cd[c] = 0; cv[c] = 0;
            for (int k = 0; k < DEP; k++) mbuf[c][k] = 0;
        end
        mq = '0;
    endtask

    function automatic int sat(input int v, input bit up, input bit bip);
        int hi, lo;
        hi = bip ? 127 : 255;
        lo = bip ? -127 : 0;
        if (up) return (v + 1 > hi) ? hi : v + 1;
        return (v - 1 < lo) ? lo : v - 1;
    endfunction

    function automatic int mag(input int v, input bit bip);
        if (!bip) return v;
        return (v < 0 ? -v : v) * 2;
    endfunction

    task automatic model_step();
        bit rd, rv, qu, sd, sv;
        int idx;
        if (rst) begin
            model_clear();
            mmode = 0;
        end else if (en) begin
            if (bipolar != mmode) begin
                model_clear();
                mmode = bipolar;
            end else begin
                idx = int'(randNum) % DEP;
                for (int c = 0; c < CH; c++) begin
                    rd = mag(cd[c], bipolar) > int'(randNum);
                    rv = mag(cv[c], bipolar) > int'(randNum);
                    sd = bipolar && cd[c] < 0;
                    sv = bipolar && cv[c] < 0;
                    qu = rv ? rd : mbuf[c][idx];
                    if (rv) begin
                        for (int k = DEP - 1; k > 0; k--) mbuf[c][k] = mbuf[c][k-1];
                        mbuf[c][0] = rd;
                    end
                    mq[c] = qu ^ sd ^ sv;
                    cd[c] = sat(cd[c], dividend[c], bipolar);
                    cv[c] = sat(cv[c], divisor[c], bipolar);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [CH-1:0] got,
                         input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock: apply inputs, advance model on the edge, compare 1 time unit later.
    task automatic cyc(input logic r, input logic e, input logic b,
                       input logic [BW-1:0] rn, input logic [CH-1:0] dd,
                       input logic [CH-1:0] dv);
        rst = r; en = e; bipolar = b; randNum = rn; dividend = dd; divisor = dv;
        @(posedge clk);
        model_step();
        #1;
        check("model", quotient, mq);
    endtask

    initial begin
        rst = 1; en = 0; bipolar = 0; randNum = '0; dividend = '0; divisor = '0;
        mmode = 0;
        model_clear();

        // Reset with arbitrary inputs, then stall with en=0
        for (int n = 0; n < 2; n++) begin
            cyc(1, $urandom_range(0, 1), $urandom_range(0, 1), BW'($urandom),
                CH'($urandom), CH'($urandom));
            check("reset_q", quotient, 2'b00);
        end
        for (int n = 0; n < 5; n++) begin
            cyc(0, 0, 0, BW'($urandom), CH'($urandom), CH'($urandom));
            check("hold_q", quotient, 2'b00);
        end

        // Unipolar saturation
        for (int n = 0; n < 300; n++) cyc(0, 1, 0, BW'($urandom), 2'b11, 2'b11);
        check_int("uni_sat_cd", cd[0], 255);
        check_int("uni_sat_cv", cv[1], 255);
        cyc(0, 1, 0, 8'd0, 2'b11, 2'b11);
        check("uni_sat_q_rn0", quotient, 2'b11);
        cyc(0, 1, 0, 8'd254, 2'b11, 2'b11);
        check("uni_sat_q_rn254", quotient, 2'b11);
        cyc(0, 1, 0, 8'd255, 2'b11, 2'b11);
        check("uni_sat_q_rn255", quotient, 2'b11);

        // Unipolar zero divisor
        cyc(1, 1, 0, 8'd0, 2'b00, 2'b00);
        for (int n = 0; n < 100; n++) begin
            cyc(0, 1, 0, BW'($urandom), 2'b11, 2'b00);
            if (quotient !== 2'b00) check("zero_div_q", quotient, 2'b00);
        end
        check("zero_div_q_end", quotient, 2'b00);

        // Switch to bipolar: first enabled edge clears
        cyc(0, 1, 1, BW'($urandom), 2'b00, 2'b11);
        check("bip_switch_q", quotient, 2'b00);
        check_int("bip_switch_cd", cd[0], 0);
        for (int n = 0; n < 200; n++) cyc(0, 1, 1, BW'($urandom), 2'b00, 2'b11);
        check_int("bip_sign_cd", cd[0], -127);
        check_int("bip_sign_cv", cv[0], 127);
        cyc(0, 1, 1, 8'd0, 2'b00, 2'b11);
        check("bip_sign_q_rn0", quotient, 2'b00);
        cyc(0, 1, 1, 8'd253, 2'b00, 2'b11);
        check("bip_sign_q_rn253", quotient, 2'b00);

        // Bipolar no-wrap and channel isolation
        cyc(1, 1, 0, 8'd0, 2'b00, 2'b00);
        cyc(0, 1, 1, 8'd0, 2'b00, 2'b00);
        for (int n = 0; n < 300; n++)
            cyc(0, 1, 1, BW'($urandom), {~n[0], 1'b1}, CH'($urandom));
        check_int("bip_nowrap_cd0", cd[0], 127);
        checks++;
        if (cd[1] < 0 || cd[1] > 1) begin
            errors++;
            $display("FAIL bip_iso_cd1 got=%0d exp=0..1", cd[1]);
        end

        // Mode toggle with en=1, then with en=0 held until en rises
        cyc(0, 1, 0, BW'($urandom), 2'b11, 2'b11);
        check("toggle_en1_q", quotient, 2'b00);
        check_int("toggle_en1_cd", cd[0], 0);
        for (int n = 0; n < 20; n++) cyc(0, 1, 0, BW'($urandom), 2'b11, 2'b01);
        for (int n = 0; n < 3; n++) cyc(0, 0, 1, BW'($urandom), CH'($urandom), CH'($urandom));
        cyc(0, 1, 1, BW'($urandom), 2'b11, 2'b11);
        check("toggle_en0_q", quotient, 2'b00);

        // Randomized soak with occasional reset, stall and mode flips
        for (int n = 0; n < 3000; n++)
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                (($urandom_range(0, 99) == 0) ? ~bipolar : bipolar),
                BW'($urandom), CH'($urandom), CH'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordiv_is_mc.md
# cordiv_is_mc

Multi-channel, mode-selectable stochastic divider with in-stream bitstream regeneration. It is the parametrised successor to the single-channel bipolar in-stream CORDIV divider, and handles CH independent dividend/divisor stream pairs. Each pair is regenerated through saturating up/down estimators (no wrap-around), in unipolar or bipolar mode selected at run time, then divided by a per-channel CORDIV shuffle buffer of depth DEP. Outputs are registered. The block sits between stream sources (SNGs or upstream kernels) and downstream unary arithmetic or counters.

## Interface
- BW, 8: estimator counter width and randNum width.
- DEP, 4: CORDIV shuffle-buffer depth per channel; must be a power of two, ≥2.
- DEPLOG, 2: log2(DEP).
- CH, 2: number of independent channels.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  advance enable; when low, all state holds.
- bipolar  in  1  mode: 0 = unipolar, 1 = bipolar.
- randNum  in  BW  shared random number for regeneration compare and buffer index.
- dividend  in  CH  dividend stream bit per channel.
- divisor  in  CH  divisor stream bit per channel.
- quotient  out  CH  registered quotient stream bit per channel.

## Operation
- Per channel there are two BW-bit estimator counters, one for the dividend (cd) and one for the divisor (cv). They update only when en=1.
- Unipolar counters are unsigned: +1 on input 1, −1 on input 0, saturating at 0 and 2^BW−1.
  - Magnitude m = cnt; sign s = 0.
- Bipolar counters are two's complement: +1 on input 1, −1 on input 0, saturating at +(2^(BW−1)−1) and −(2^(BW−1)−1). The value −2^(BW−1) is never reached.
  - s = cnt[BW−1]; m = |cnt| << 1 (BW bits, LSB 0).
- Regenerated bit r = (m > randNum), unsigned compare, evaluated from current (pre-update) counter values.
- Kernel per channel: DEP-bit buffer B, index i = randNum[DEPLOG−1:0].
  - If rv=1: q_uni = rd; B shifts in rd at B[0], oldest bit discarded.
  - If rv=0: q_uni = B[i]; B unchanged.
- Output: quotient_next = q_uni in unipolar mode, or q_uni ^ sd ^ sv in bipolar mode.
- All channels share randNum and bipolar but are otherwise fully independent.

## Timing
- Reset: rst=1 at an edge clears all counters to 0, all buffers to 0, and quotient to 0. rst dominates en.
- An input bit sampled at edge t updates the counters at t. Its effect on r appears in cycle t..t+1 and on quotient after edge t+1. Latency from input to quotient influence is 2 edges.
- quotient updates at every edge with en=1. With en=0, quotient, counters and buffers all hold.
- Mode change: if bipolar differs from its value registered at the previous edge, the next edge with en=1 clears counters and buffers to 0 and loads quotient with 0 (same as reset). Normal operation resumes at the following edge. The registered mode copy resets to 0.
- Saturation: an increment at max or a decrement at min leaves the counter unchanged. Simultaneous saturation in both counters is legal.
- randNum = 2^BW−1 forces r=0 for every counter value.
- rst asserted mid-stream fully reinitialises state; no partial buffer contents survive.

## Test plan
- Reset: rst=1 for 2 edges with arbitrary inputs → quotient=0, all counters 0; after release with en=0 for 5 cycles, quotient stays 0.
- Unipolar saturation (BW=8): dividend=divisor=1 for 300 cycles, randNum uniform → cd=cv=255 after 255 edges, no wrap. quotient=1 whenever randNum<255.
- Unipolar zero divisor: divisor=0, dividend=1 for 100 cycles → rv never 1, buffer stays 0, quotient=0 throughout.
- Bipolar sign (BW=8): dividend=0, divisor=1 for 200 cycles → cd=−127 (m=254), cv=+127, sd=1, sv=0. quotient=0 (value −1) whenever randNum<254.
- Bipolar no-wrap and channel isolation: ch0 dividend=1 for 300 cycles → cd0 holds 127. Ch1 driven with alternating 1/0 → cd1 oscillates between 0 and 1, unaffected by ch0.
- Mode switch / en: mid-stream toggle bipolar with en=1 → next edge counters and buffers are 0 and quotient=0. Toggle with en=0 → no change until en rises, then the clear occurs.
